// File: rtl/cpu_timer.sv
// Machine timer and software-interrupt source: 64-bit mtime with prescaler,
// 64-bit mtimecmp compare, msip bit, behind a single-cycle peripheral bus.
module cpu_timer #(
    parameter int XLEN       = 32,
    parameter int PRESCALE_W = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req,
    input  logic            i_we,
    input  logic [4:0]      i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_rvalid,
    output logic            o_mti_pending,
    output logic            o_msi_pending
);
    // Bus handshake: i_req is always accepted (no ready); a read issued at
    // edge k returns o_rdata with a one-cycle o_rvalid after edge k, writes
    // never respond, and o_rdata holds its last value while o_rvalid is low.

    localparam logic [2:0] OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] OFF_MSIP     = 3'd4;
    localparam logic [2:0] OFF_PRESCALE = 3'd5;

    logic [63:0]           r_mtime;
    logic [63:0]           r_mtimecmp;
    logic [31:0]           r_hi_snap;
    logic                  r_msip;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic [XLEN-1:0]       r_rdata;
    logic                  r_rvalid;
    logic                  r_mti;

    logic [2:0]      w_off;
    logic            w_wr;
    logic            w_rd;
    logic            w_wr_lo;
    logic            w_wr_hi;
    logic            w_wr_pre;
    logic            w_tick;
    logic [XLEN-1:0] w_rdata_nxt;

    assign w_off    = i_addr[4:2];
    assign w_wr     = i_req & i_we;
    assign w_rd     = i_req & ~i_we;
    assign w_wr_lo  = w_wr && (w_off == OFF_MTIME_LO);
    assign w_wr_hi  = w_wr && (w_off == OFF_MTIME_HI);
    assign w_wr_pre = w_wr && (w_off == OFF_PRESCALE);
    assign w_tick   = (r_pcnt == r_prescale);

    always_comb begin
        w_rdata_nxt = '0;
        case (w_off)
            OFF_MTIME_LO: w_rdata_nxt = r_mtime[31:0];
            OFF_MTIME_HI: w_rdata_nxt = r_hi_snap;
            OFF_CMP_LO:   w_rdata_nxt = r_mtimecmp[31:0];
            OFF_CMP_HI:   w_rdata_nxt = r_mtimecmp[63:32];
            OFF_MSIP:     w_rdata_nxt = {{(XLEN-1){1'b0}}, r_msip};
            OFF_PRESCALE: w_rdata_nxt = {{(XLEN-PRESCALE_W){1'b0}}, r_prescale};
            default:      w_rdata_nxt = '0;
        endcase
    end

    // Prescaler: a PRESCALE write restarts the count; otherwise wrap on tick.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pcnt <= '0;
        end else if (w_wr_pre || w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + PRESCALE_W'(1);
        end
    end

    // A software write to either half (or to PRESCALE) swallows that cycle's tick.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mtime <= '0;
        end else if (w_wr_lo) begin
            r_mtime[31:0] <= i_wdata;
        end else if (w_wr_hi) begin
            r_mtime[63:32] <= i_wdata;
        end else if (w_tick && !w_wr_pre) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mtimecmp <= '1;
            r_msip     <= 1'b0;
            r_prescale <= '0;
        end else if (w_wr) begin
            case (w_off)
                OFF_CMP_LO:   r_mtimecmp[31:0]  <= i_wdata;
                OFF_CMP_HI:   r_mtimecmp[63:32] <= i_wdata;
                OFF_MSIP:     r_msip            <= i_wdata[0];
                OFF_PRESCALE: r_prescale        <= i_wdata[PRESCALE_W-1:0];
                default:      ;
            endcase
        end
    end

    // Reading LO freezes HI so a LO-then-HI pair is a coherent 64-bit sample.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
            r_hi_snap <= '0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rdata_nxt;
                if (w_off == OFF_MTIME_LO) begin
                    r_hi_snap <= r_mtime[63:32];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mti <= 1'b0;
        end else begin
            r_mti <= (r_mtime >= r_mtimecmp);
        end
    end

    assign o_rdata       = r_rdata;
    assign o_rvalid      = r_rvalid;
    assign o_mti_pending = r_mti;
    assign o_msi_pending = r_msip;

endmodule

// File: tb/tb_cpu_timer.sv
// Bench for cpu_timer: reset, register table, hand-written timing sequences,
// then random bus traffic checked against a cycle-count reference model.
module tb_cpu_timer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        mti;
  logic        msi;

  cpu_timer #(.XLEN(32), .PRESCALE_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .o_rdata(rdata), .o_rvalid(rvalid),
    .o_mti_pending(mti), .o_msi_pending(msi)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state: mtime advances once every (prescale+1) cycles
  // counted from the last prescale restart.
  logic [63:0] m_mtime, m_cmp;
  logic [31:0] m_snap, m_rdata;
  logic        m_msip, m_mti, m_rvalid;
  int unsigned m_pre, m_age;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_mtime = '0; m_cmp = '1; m_snap = '0; m_rdata = '0;
    m_msip = 0; m_mti = 0; m_rvalid = 0; m_pre = 0; m_age = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic        tick;
    logic        wr_time;
    logic [31:0] rd;
    logic [2:0]  off;
    off = addr[4:2];
    tick = (m_age % (m_pre + 1)) == m_pre;
    m_mti = (m_mtime >= m_cmp);
    m_rvalid = 0;
    if (req && !we) begin
      case (off)
        3'd0: rd = m_mtime[31:0];
        3'd1: rd = m_snap;
        3'd2: rd = m_cmp[31:0];
        3'd3: rd = m_cmp[63:32];
        3'd4: rd = {31'b0, m_msip};
        3'd5: rd = m_pre;
        default: rd = '0;
      endcase
      if (off == 3'd0) m_snap = m_mtime[63:32];
      m_rdata = rd;
      m_rvalid = 1;
      exp_q.push_back(rd);
    end
    wr_time = req && we && (off <= 3'd1);
    if (req && we) begin
      case (off)
        3'd0: m_mtime[31:0] = wdata;
        3'd1: m_mtime[63:32] = wdata;
        3'd2: m_cmp[31:0] = wdata;
        3'd3: m_cmp[63:32] = wdata;
        3'd4: m_msip = wdata[0];
        3'd5: m_pre = {16'b0, wdata[15:0]};
        default: ;
      endcase
    end
    if (req && we && off == 3'd5) begin
      m_age = 0;
    end else begin
      if (tick && !wr_time) m_mtime = m_mtime + 64'd1;
      m_age++;
    end
  endtask

  task automatic cycle(input logic rq, input logic w, input logic [4:0] a, input logic [31:0] d);
    req = rq; we = w; addr = a; wdata = d;
    model_step();
    @(posedge clk);
    #1;
    check("rvalid", rvalid, m_rvalid);
    if (m_rvalid) check("rdata", rdata, exp_q.pop_front());
    else check("rdata_hold", rdata, m_rdata);
    check("mti_pending", mti, m_mti);
    check("msi_pending", msi, m_msip);
    req = 0; we = 0;
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [31:0] e, input string name);
    cycle(1, 0, a, 0);
    check(name, rdata, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] pre_exp[8];
    logic        rq, w;
    logic [2:0]  off;
    logic [31:0] d;

    tbl[0]  = '{1, 5'h08, 32'h1234_5678, 0};
    tbl[1]  = '{0, 5'h08, 0, 32'h1234_5678};
    tbl[2]  = '{1, 5'h0C, 32'hDEAD_BEEF, 0};
    tbl[3]  = '{0, 5'h0C, 0, 32'hDEAD_BEEF};
    tbl[4]  = '{0, 5'h08, 0, 32'h1234_5678};
    tbl[5]  = '{1, 5'h10, 32'hFFFF_FFFF, 0};
    tbl[6]  = '{0, 5'h10, 0, 32'h0000_0001};
    tbl[7]  = '{1, 5'h10, 32'hFFFF_FFFE, 0};
    tbl[8]  = '{0, 5'h10, 0, 32'h0000_0000};
    tbl[9]  = '{1, 5'h14, 32'hABCD_EF01, 0};
    tbl[10] = '{0, 5'h14, 0, 32'h0000_EF01};
    tbl[11] = '{1, 5'h14, 32'h0, 0};
    tbl[12] = '{0, 5'h18, 0, 32'h0};
    tbl[13] = '{1, 5'h18, 32'h5555_5555, 0};
    tbl[14] = '{0, 5'h18, 0, 32'h0};
    tbl[15] = '{1, 5'h1C, 32'h1, 0};
    tbl[16] = '{0, 5'h1C, 0, 32'h0};
    tbl[17] = '{1, 5'h08, 32'hFFFF_FFFF, 0};
    tbl[18] = '{1, 5'h0C, 32'hFFFF_FFFF, 0};
    tbl[19] = '{0, 5'h0C, 0, 32'hFFFF_FFFF};
    tbl[20] = '{1, 5'h10, 32'hFFFF_FFFF, 0};
    pre_exp = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2};

    // Reset release and free-running count.
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    check("reset_rvalid", rvalid, 0);
    check("reset_rdata", rdata, 0);
    check("reset_mti", mti, 0);
    check("reset_msi", msi, 0);
    rd_chk(5'h00, 32'd0, "reset_first_lo");
    idle(4);
    rd_chk(5'h00, 32'd5, "reset_lo_after5");

    // Register table.
    for (int i = 0; i < 21; i++) begin
      cycle(1, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      if (!tbl[i].we) check($sformatf("tbl_%0d", i), rdata, tbl[i].exp);
    end
    check("msip_sets_msi", msi, 1);
    cycle(1, 1, 5'h10, 32'h0);
    check("msip_clears_msi", msi, 0);

    // Prescaler 3 then back to 0.
    cycle(1, 1, 5'h14, 32'd3);
    cycle(1, 1, 5'h00, 32'd0);
    for (int i = 0; i < 8; i++) rd_chk(5'h00, pre_exp[i], $sformatf("pre3_rd%0d", i));
    cycle(1, 1, 5'h14, 32'd0);
    rd_chk(5'h00, 32'd2, "pre0_rd0");
    rd_chk(5'h00, 32'd3, "pre0_rd1");
    rd_chk(5'h00, 32'd4, "pre0_rd2");

    // Carry into HI and snapshot.
    cycle(1, 1, 5'h04, 32'h1);
    cycle(1, 1, 5'h00, 32'hFFFF_FFFE);
    idle(1);
    rd_chk(5'h00, 32'hFFFF_FFFF, "carry_lo_a");
    rd_chk(5'h00, 32'h0000_0000, "carry_lo_b");
    rd_chk(5'h04, 32'h0000_0002, "carry_hi_snap");
    // Full 64-bit wrap.
    cycle(1, 1, 5'h04, 32'hFFFF_FFFF);
    cycle(1, 1, 5'h00, 32'hFFFF_FFFF);
    rd_chk(5'h00, 32'hFFFF_FFFF, "wrap_lo_a");
    rd_chk(5'h00, 32'h0, "wrap_lo_b");
    rd_chk(5'h04, 32'h0, "wrap_hi");

    // Interrupt at mtime == 20, one edge of compare latency.
    cycle(1, 1, 5'h04, 32'h0);
    cycle(1, 1, 5'h08, 32'd20);
    cycle(1, 1, 5'h0C, 32'h0);
    cycle(1, 1, 5'h00, 32'h0);
    for (int n = 1; n <= 23; n++) begin
      idle(1);
      check($sformatf("mti_edge%0d", n), mti, (n >= 21) ? 1'b1 : 1'b0);
    end
    cycle(1, 1, 5'h08, 32'hFFFF_FFFF);
    check("mti_hold_after_cmp_write", mti, 1);
    idle(1);
    check("mti_drop", mti, 0);

    // Write colliding with a tick.
    cycle(1, 1, 5'h00, 32'd100);
    rd_chk(5'h00, 32'd100, "collide_rd0");
    idle(3);
    rd_chk(5'h00, 32'd104, "collide_rd1");

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rq = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1);
      off = 3'($urandom_range(0, 7));
      if (off == 3'd5) d = $urandom_range(0, 3);
      else if ($urandom_range(0, 1) == 0) d = $urandom_range(0, 40);
      else d = $urandom;
      cycle(rq, w, {off, 2'b00}, d);
    end

    // Reset in the middle of a read.
    cycle(1, 1, 5'h08, 32'h0);
    cycle(1, 1, 5'h0C, 32'h0);
    cycle(1, 1, 5'h10, 32'h1);
    cycle(1, 1, 5'h14, 32'h0);
    rd_chk(5'h10, 32'h1, "pre_rst_msip");
    idle(1);
    check("pre_rst_mti", mti, 1);
    req = 1; we = 0; addr = 5'h10;
    @(negedge clk);
    rst = 1;
    #1;
    check("rst_async_rvalid", rvalid, 0);
    check("rst_async_rdata", rdata, 0);
    check("rst_async_mti", mti, 0);
    check("rst_async_msi", msi, 0);
    @(posedge clk);
    #1;
    check("rst_no_rvalid", rvalid, 0);
    check("rst_rdata_zero", rdata, 0);
    req = 0;
    rst = 0;
    model_reset();
    rd_chk(5'h00, 32'd0, "post_rst_lo");
    rd_chk(5'h0C, 32'hFFFF_FFFF, "post_rst_cmp_hi");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
